// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared types for the MEM stage and data bus
package memory_stage_pkg;
  localparam int XLEN = 64;
  localparam int BYTES = XLEN / 8;

  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef enum logic {IDLE, WAIT} mem_state_t;

  typedef struct packed {
    logic [5:0] op;
    logic       mem_read;
    logic       mem_write;
    msize_t     msize;
    logic       mem_unsigned;
  } control_t;

  typedef struct packed {
    logic            is_bubble;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] result;
    control_t        ctl;
    logic [4:0]      dst;
    logic [XLEN-1:0] store_data;
  } execute_data_t;

  typedef struct packed {
    logic            is_bubble;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] result;
    control_t        ctl;
    logic [4:0]      dst;
    logic [XLEN-1:0] memory_address;
    logic            misalign;
  } memory_data_t;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  addr;
    msize_t           size;
    logic [BYTES-1:0] strobe;
    logic [XLEN-1:0]  data;
  } dbus_req_t;

  typedef struct packed {
    logic            addr_ok;
    logic            data_ok;
    logic [XLEN-1:0] data;
  } dbus_resp_t;

  // is_bubble is the MSB, so this is an all-zero record flagged as a bubble
  localparam memory_data_t MEM_BUBBLE = memory_data_t'({1'b1, {($bits(memory_data_t)-1){1'b0}}});
endpackage

// File: rtl/memory_stage_align.sv
// mem_align: byte-lane alignment of store data/strobe and load extraction
module mem_align
  import memory_stage_pkg::*;
(
  input  logic [2:0]       addr,
  input  msize_t           msize,
  input  logic             isUnsigned,
  input  logic [XLEN-1:0]  storeData,
  input  logic [XLEN-1:0]  readData,
  output logic [BYTES-1:0] strobe,
  output logic [XLEN-1:0]  writeData,
  output logic [XLEN-1:0]  loadData,
  output logic             misalign
);
  logic [BYTES-1:0] mask;
  logic [XLEN-1:0] shifted;
  // shift lanes by the byte offset and extend the selected load width
  always_comb begin
    mask = msize == MSIZE1 ? 8'h01 : msize == MSIZE2 ? 8'h03 : msize == MSIZE4 ? 8'h0F : 8'hFF;
    strobe = mask << addr;
    writeData = storeData << {addr, 3'b000};
    shifted = readData >> {addr, 3'b000};
    loadData = msize == MSIZE1 ? {{56{~isUnsigned & shifted[7]}}, shifted[7:0]} :
               msize == MSIZE2 ? {{48{~isUnsigned & shifted[15]}}, shifted[15:0]} :
               msize == MSIZE4 ? {{32{~isUnsigned & shifted[31]}}, shifted[31:0]} : shifted;
    misalign = (msize == MSIZE2 && addr[0]) || (msize == MSIZE4 && addr[1:0] != 2'b00) ||
               (msize == MSIZE8 && addr != 3'b000);
  end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage driving the data-bus handshake
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  output memory_data_t  dataM,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output logic          stallM
);
  mem_state_t state, stateNext;
  logic [BYTES-1:0] strobe;
  logic [XLEN-1:0] writeData, loadData;
  logic misalign, memAccess, memOp;
  memory_data_t dataNext;

  mem_align uAlign (
    .addr(dataE.result[2:0]),
    .msize(dataE.ctl.msize),
    .isUnsigned(dataE.ctl.mem_unsigned),
    .storeData(dataE.store_data),
    .readData(dresp.data),
    .strobe(strobe),
    .writeData(writeData),
    .loadData(loadData),
    .misalign(misalign)
  );

  assign memAccess = !dataE.is_bubble && (dataE.ctl.mem_read || dataE.ctl.mem_write);
  assign memOp = memAccess && !misalign;

  // state register; reset abandons any in-flight request
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= stateNext;

  // a zero-wait data_ok completes without ever leaving IDLE
  always_comb
    stateNext = state == IDLE ? (memOp && !dresp.data_ok ? WAIT : IDLE) : (dresp.data_ok ? IDLE : WAIT);

  // bus request and stall; dataE is frozen by the stall so the request stays stable
  always_comb begin
    dreq.valid = reset && (state == WAIT || memOp);
    dreq.addr = dataE.result;
    dreq.size = dataE.ctl.msize;
    dreq.strobe = dataE.ctl.mem_write ? strobe : '0;
    dreq.data = writeData;
    stallM = dreq.valid && !dresp.data_ok;
  end

  // next stage record: bubble while stalled, otherwise pass-through or completion
  always_comb begin
    dataNext = MEM_BUBBLE;
    if (!stallM) begin
      dataNext.is_bubble = dataE.is_bubble;
      dataNext.pc = dataE.pc;
      dataNext.result = dreq.valid && dataE.ctl.mem_read ? loadData : dataE.result;
      dataNext.ctl = dataE.ctl;
      dataNext.dst = dataE.dst;
      dataNext.memory_address = memAccess ? dataE.result : '0;
      dataNext.misalign = memAccess && misalign;
    end
  end

  // stage output register
  always_ff @(posedge clk or negedge reset)
    if (!reset) dataM <= MEM_BUBBLE;
    else dataM <= dataNext;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized scoreboard bench for memory_stage
module tb_memory_stage;
  import memory_stage_pkg::*;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] result;
    logic [63:0] addr;
    logic [4:0]  dst;
    logic        mis;
    logic        isMem;
  } exp_t;

  logic clk = 0;
  logic rst_n = 0;
  execute_data_t dataE;
  memory_data_t dataM;
  dbus_req_t dreq;
  dbus_resp_t dresp;
  logic stallM;
  exp_t q[$];
  int tests = 0;
  int fails = 0;

  memory_stage dut (
    .clk(clk),
    .reset(rst_n),
    .dataE(dataE),
    .dataM(dataM),
    .dreq(dreq),
    .dresp(dresp),
    .stallM(stallM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // load value from the specification: bytes at the offset, then extend
  function automatic logic [63:0] loadModel(input logic [63:0] raw, input int off, input int n, input logic uns);
    logic [63:0] v, m;
    v = raw >> (8 * off);
    if (n == 8) return v;
    m = (64'd1 << (8 * n)) - 64'd1;
    v = v & m;
    if (!uns && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  // monitor: every non-bubble output must match the oldest expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && !dataM.is_bubble) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output actual=pc %h required=none", dataM.pc);
      end else begin
        e = q.pop_front();
        chk("out_pc", dataM.pc, e.pc);
        chk("out_result", dataM.result, e.result);
        chk("out_dst", 64'(dataM.dst), 64'(e.dst));
        chk("out_misalign", 64'(dataM.misalign), 64'(e.mis));
        if (e.isMem) chk("out_addr", dataM.memory_address, e.addr);
      end
    end
  end

  task automatic doInstr(input logic bub, input logic rd, input logic wr, input int sz, input logic uns,
                         input logic [63:0] pc, input logic [63:0] addr, input logic [4:0] dst,
                         input logic [63:0] sd, input logic [63:0] raw, input int lat);
    int n, off;
    logic mis, isMem;
    logic [7:0] stb;
    exp_t e;
    n = 1 << sz;
    off = int'(addr[2:0]);
    mis = (addr % n) != 0;
    isMem = !bub && (rd || wr);
    stb = '0;
    for (int i = 0; i < n; i++) if (off + i < 8) stb[off+i] = 1'b1;
    @(negedge clk);
    dataE.is_bubble = bub;
    dataE.pc = pc;
    dataE.result = addr;
    dataE.ctl.op = 6'($urandom);
    dataE.ctl.mem_read = rd;
    dataE.ctl.mem_write = wr;
    dataE.ctl.msize = msize_t'(sz);
    dataE.ctl.mem_unsigned = uns;
    dataE.dst = dst;
    dataE.store_data = sd;
    dresp.data_ok = 1'b0;
    dresp.addr_ok = 1'($urandom);
    dresp.data = raw;
    if (!bub) begin
      e.pc = pc;
      e.result = (isMem && rd && !mis) ? loadModel(raw, off, n, uns) : addr;
      e.addr = addr;
      e.dst = dst;
      e.mis = isMem && mis;
      e.isMem = isMem && !mis;
      q.push_back(e);
    end
    if (isMem && !mis) begin
      for (int c = 0; c <= lat; c++) begin
        if (c > 0) @(negedge clk);
        dresp.data_ok = (c == lat);
        #1;
        chk("req_valid", 64'(dreq.valid), 64'd1);
        chk("req_addr", dreq.addr, addr);
        chk("req_strobe", 64'(dreq.strobe), wr ? 64'(stb) : 64'd0);
        if (wr) chk("req_data", dreq.data, sd << (8 * off));
        chk("stall", 64'(stallM), 64'(c != lat));
      end
    end else begin
      #1;
      chk("idle_valid", 64'(dreq.valid), 64'd0);
      chk("idle_stall", 64'(stallM), 64'd0);
    end
  endtask

  initial begin
    int kind, sz;
    dataE = '0;
    dataE.is_bubble = 1'b1;
    dresp = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_bubble", 64'(dataM.is_bubble), 64'd1);
    chk("rst_valid", 64'(dreq.valid), 64'd0);
    chk("rst_stall", 64'(stallM), 64'd0);
    rst_n = 1'b1;
    doInstr(0, 0, 0, 3, 0, 64'h80000000, 64'h5, 5'd3, 64'h0, 64'h0, 0);
    doInstr(0, 0, 1, 3, 0, 64'h80000004, 64'h80001008, 5'd0, 64'h1122334455667788, 64'h0, 3);
    doInstr(0, 1, 0, 0, 0, 64'h80000008, 64'h80002003, 5'd4, 64'h0, 64'h0000000080000000, 0);
    doInstr(0, 1, 0, 0, 1, 64'h8000000c, 64'h80002003, 5'd5, 64'h0, 64'h0000000080000000, 0);
    doInstr(0, 0, 1, 1, 0, 64'h80000010, 64'h80003006, 5'd0, 64'hABCD, 64'h0, 1);
    doInstr(0, 1, 0, 2, 0, 64'h80000014, 64'h80004002, 5'd6, 64'h0, 64'h0, 0);
    doInstr(1, 0, 0, 0, 0, 64'h80000018, 64'h7, 5'd7, 64'h0, 64'h0, 0);
    // reset while a load is waiting: abandoned, late data_ok ignored
    @(negedge clk);
    dataE.is_bubble = 1'b0;
    dataE.ctl.mem_read = 1'b1;
    dataE.ctl.mem_write = 1'b0;
    dataE.ctl.msize = MSIZE8;
    dataE.result = 64'h80005000;
    dresp.data_ok = 1'b0;
    #1;
    chk("wait_stall", 64'(stallM), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(dreq.valid), 64'd0);
    chk("abort_bubble", 64'(dataM.is_bubble), 64'd1);
    @(negedge clk);
    dataE.is_bubble = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    dresp.data_ok = 1'b1;
    @(negedge clk);
    dresp.data_ok = 1'b0;
    #1;
    chk("late_ok_valid", 64'(dreq.valid), 64'd0);
    chk("late_ok_bubble", 64'(dataM.is_bubble), 64'd1);
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 6);
      sz = $urandom_range(0, 3);
      doInstr(kind == 6, kind inside {1, 2}, kind inside {3, 4}, sz, 1'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
    end
    @(negedge clk);
    dataE.is_bubble = 1'b1;
    dresp.data_ok = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM pipeline stage of the RV64 core: consumes execute_data_t from EX and produces the registered memory_data_t that feeds the writeback stage.
- Drives the data-bus request/response handshake (dbus_req_t / dbus_resp_t) for loads and stores.
- Aligns store data and strobes; extracts and sign/zero-extends load data.
- Stalls upstream while a bus transaction is outstanding.

Parameters:
- XLEN, 64, datapath and address width.
- BYTES, XLEN/8, strobe width.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- dataE  in  execute_data_t  EX result: is_bubble, pc, result (ALU value / effective address), ctl (op, mem_read, mem_write, msize, mem_unsigned), dst, store_data.
- dataM  out  memory_data_t  registered stage output to writeback.
- dreq  out  dbus_req_t  valid, addr[XLEN], size, strobe[BYTES], data[XLEN].
- dresp  in  dbus_resp_t  addr_ok, data_ok, data[XLEN].
- stallM  out  1  hold EX/ID/IF registers this cycle.

Behaviour:
- Reset (reset low, async):
  - state=IDLE.
  - dataM all zero with dataM.is_bubble=1.
  - dreq.valid=0, stallM=0.
  - An in-flight request is abandoned; no completion is reported after release.
- FSM states:
  - IDLE: no transaction outstanding.
  - WAIT: request issued, awaiting dresp.data_ok.
- Memory op = !dataE.is_bubble && (mem_read || mem_write) && !misaligned.
- IDLE, non-memory or bubble input:
  - dreq.valid=0, stallM=0.
  - Next edge: dataM <= dataE fields (pc, result, ctl, dst, is_bubble). Latency 1 cycle.
- IDLE, memory op:
  - Combinationally assert dreq.valid=1 with addr=dataE.result, size=msize, aligned strobe and data.
  - If dresp.data_ok is high the same cycle: stallM=0, completion per the completion rule below, state stays IDLE (zero-wait case).
  - Otherwise: stallM=1, state->WAIT, dataM.is_bubble<=1.
- WAIT:
  - dreq.valid held 1; addr/size/strobe/data held stable (dataE is frozen by stallM).
  - addr_ok is ignored.
  - On data_ok: stallM=0, state->IDLE, completion.
  - Otherwise: stallM=1, dataM.is_bubble<=1.
- Completion: next edge, dataM <= dataE fields with is_bubble=0; for loads, result <= extended load value; memory_address <= addr.
- Store alignment, off=addr[2:0]:
  - strobe = size mask << off.
  - data = store_data << (8*off).
  - Byte/half/word/dword masks are 0x01/0x03/0x0F/0xFF.
- Loads: strobe=0. Extract bytes at off, then sign-extend, or zero-extend when mem_unsigned.
- Misaligned access (half with addr[0]≠0, word with addr[1:0]≠0, dword with addr[2:0]≠0):
  - No request issued.
  - dataM passes through with dataM.misalign=1 and is_bubble=0; destination write is suppressed downstream.
- Only one transaction is outstanding at a time. A data_ok seen in IDLE with no request is ignored.

Decomposition:
- common package:
  - execute_data_t, memory_data_t (adds misalign bit), dbus_req_t, dbus_resp_t.
  - msize_t enum: MSIZE1/2/4/8.
  - mem_state_t enum: IDLE/WAIT.
- One combinational sub-module: mem_align. Inputs: addr[2:0], msize, unsigned flag, store_data, raw read data. Outputs: strobe, shifted write data, extended load data, misalign.

Test Plan:
- ADD, pc=0x80000000, result=0x5, dst=3, no bus activity -> next cycle dataM.result=0x5, dst=3, is_bubble=0; dreq.valid never 1, stallM=0.
- SD to addr 0x80001008, store_data=0x1122334455667788, data_ok after 3 cycles:
  - dreq.strobe=0xFF for all 4 cycles; stallM high for 3 cycles.
  - dataM bubble for 3 cycles, then valid with memory_address=0x80001008.
- LB at addr 0x...03, dresp.data=0x00000000_80000000 returned zero-wait -> same-cycle completion; dataM.result=0xFFFFFFFFFFFFFF80. LBU same setup -> 0x80.
- SH at addr 0x...06, store_data=0xABCD -> strobe=0xC0, data=0xABCD000000000000.
- LW at addr 0x...02 -> no dreq.valid; dataM.misalign=1 next cycle; stallM=0.
- Load in WAIT, reset pulled low before data_ok -> dreq.valid=0 immediately, dataM.is_bubble=1; after release, a late data_ok is ignored and state=IDLE.
